// File: rtl/flip_flop_fifo_with_level_flags_if.sv
// Bus bundle for flip_flop_fifo_with_level_flags: push/pop requests, data and status flags.
// master = producer/consumer side, slave = the FIFO itself.
interface flip_flop_fifo_with_level_flags_if #(
    parameter int width = 8,
    parameter int depth = 10
);
    logic                           push;
    logic                           pop;
    logic [width-1:0]               write_data;
    logic [width-1:0]               read_data;
    logic                           empty;
    logic                           full;
    logic                           almost_empty;
    logic                           almost_full;
    logic [$clog2(depth + 1)-1:0]   count;
    logic                           overflow;
    logic                           underflow;

    modport master (
        output push, pop, write_data,
        input  read_data, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, write_data,
        output read_data, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/flip_flop_fifo_with_level_flags.sv
// Flip-flop FIFO of arbitrary depth with registered count and empty/full/almost flags.
// Define FIFO_ERROR_FLAGS_EN to build sticky overflow/underflow error flags.
module flip_flop_fifo_with_level_flags #(
    parameter int width              = 8,
    parameter int depth              = 10,
    parameter int almost_empty_level = 1,
    parameter int almost_full_level  = depth - 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    flip_flop_fifo_with_level_flags_if.slave         bus
);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    localparam logic [PW-1:0] LAST_PTR   = PW'(depth - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(depth);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(almost_empty_level);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(almost_full_level);
    localparam bit            AF_AT_ZERO = (almost_full_level == 0);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_almost_empty;
    logic             r_almost_full;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CW-1:0]    w_count_next;
    logic [PW-1:0]    w_wr_ptr_inc;
    logic [PW-1:0]    w_rd_ptr_inc;

    // Acceptance uses only registered flags, so a pop frees the slot a same-cycle push needs.
    assign w_push_ok = bus.push & (~r_full | bus.pop);
    assign w_pop_ok  = bus.pop & ~r_empty;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    assign w_wr_ptr_inc = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);

    // NOTE: combinational block assigns a default first so no path leaves w_count_next unassigned (no latch).
    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= AF_AT_ZERO;
        end else begin
            if (w_push_ok) r_wr_ptr <= w_wr_ptr_inc;
            if (w_pop_ok)  r_rd_ptr <= w_rd_ptr_inc;
            r_count        <= w_count_next;
            r_empty        <= (w_count_next == '0);
            r_full         <= (w_count_next == DEPTH_C);
            r_almost_empty <= (w_count_next <= AE_LEVEL);
            r_almost_full  <= (w_count_next >= AF_LEVEL);
        end
    end

    // NOTE: storage has no reset; empty/count already guard it, and a reset array would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) r_mem[r_wr_ptr] <= bus.write_data;
    end

    assign bus.read_data    = r_mem[r_rd_ptr];
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.count        = r_count;

`ifdef FIFO_ERROR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky until reset; a rejected push or an ignored pop leaves its mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.push & r_full & ~bus.pop) r_overflow  <= 1'b1;
            if (bus.pop & r_empty)            r_underflow <= 1'b1;
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule
